datamem_ctrl: RTL and testbench

DATAMEM_CTRL -- requirements
Module: datamem_ctrl

---
 rtl/datamem_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_datamem_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_ctrl.sv
// datamem_ctrl: single-port data memory with a fixed-latency request/response
// handshake. A request is accepted in IDLE, held for WAIT_CYCLES wait states,
// then executed on the edge entering RESP, which drives a one-cycle response.
// Optional build macro: DATAMEM_ALIGN_CHECK_EN rejects misaligned half/word
// accesses; without it the misaligned low address bits are ignored.
module datamem_ctrl #(
  parameter int unsigned DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFFFF00,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Contents start at zero and are deliberately outside the reset domain.
  logic [31:0] mem_q [DEPTH] = '{default: '0};

  // Request fields seen by the datapath: live inputs while IDLE (needed when
  // WAIT_CYCLES=0 executes on the accept edge), registered copy afterwards.
  logic        cur_wr;
  logic [1:0]  cur_size;
  logic        cur_sgn;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic [31:0] off;
  logic        bad;
  logic [IW-1:0] mem_idx;
  logic [31:0] rd_word;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] load_val;
  logic [31:0] st_mask, st_data, mem_wdata;
  logic        mem_we;
  logic        accept, go_resp;

  // Next-state, request capture, address decode and load/store datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = '0;
    err_d   = 1'b0;
    mem_we  = 1'b0;

    if (state_q == IDLE) begin
      cur_wr = req_write; cur_size = req_size; cur_sgn = req_signed;
      cur_addr = req_addr; cur_wdata = req_wdata;
    end else begin
      cur_wr = wr_q; cur_size = size_q; cur_sgn = sgn_q;
      cur_addr = addr_q; cur_wdata = wdata_q;
    end

    // Out-of-window, illegal size, and (optionally) misalignment all reject.
    off = cur_addr - BASE_ADDR;
    bad = (cur_addr < BASE_ADDR) || ((off >> 2) >= DEPTH) || (cur_size == 2'b11);
`ifdef DATAMEM_ALIGN_CHECK_EN
    bad = bad || (cur_size == 2'b01 && cur_addr[0]) ||
                 (cur_size == 2'b10 && cur_addr[1:0] != 2'b00);
`endif
    mem_idx = off[IW+1:2];
    rd_word = mem_q[mem_idx];

    // Little-endian lane select with optional sign extension.
    bsel = rd_word[{cur_addr[1:0], 3'b000} +: 8];
    hsel = rd_word[{cur_addr[1], 4'b0000} +: 16];
    case (cur_size)
      2'b00:   load_val = {{24{cur_sgn & bsel[7]}}, bsel};
      2'b01:   load_val = {{16{cur_sgn & hsel[15]}}, hsel};
      default: load_val = rd_word;
    endcase

    // Read-modify-write merge so untouched lanes keep their value.
    case (cur_size)
      2'b00: begin
        st_mask = 32'h0000_00FF << {cur_addr[1:0], 3'b000};
        st_data = {24'b0, cur_wdata[7:0]} << {cur_addr[1:0], 3'b000};
      end
      2'b01: begin
        st_mask = 32'h0000_FFFF << {cur_addr[1], 4'b0000};
        st_data = {16'b0, cur_wdata[15:0]} << {cur_addr[1], 4'b0000};
      end
      default: begin
        st_mask = 32'hFFFF_FFFF;
        st_data = cur_wdata;
      end
    endcase
    mem_wdata = (rd_word & ~st_mask) | (st_data & st_mask);

    accept  = 1'b0;
    go_resp = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        accept = 1'b1;
        if (WAIT_CYCLES == 0) begin
          go_resp = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = 4'(WAIT_CYCLES - 1);
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) begin
        go_resp = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      wr_d = req_write; size_d = req_size; sgn_d = req_signed;
      addr_d = req_addr; wdata_d = req_wdata;
    end

    if (go_resp) begin
      err_d   = bad;
      rdata_d = (bad || cur_wr) ? 32'h0 : load_val;
      // Never touch memory while reset is held.
      mem_we  = cur_wr && !bad && rst_n;
    end
  end

  // Control and response registers, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array write port; no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_wdata;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_datamem_ctrl.sv
// tb_datamem_ctrl: directed + random checks of datamem_ctrl against a
// byte-array reference model. A second instance uses WAIT_CYCLES=0.
module tb_datamem_ctrl;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'hFFFFFF00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid1, req_ready1, req_write1, req_signed1;
  logic [1:0]  req_size1;
  logic [31:0] req_addr1, req_wdata1;
  logic        rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mb [DEPTH*4];

  always #5 clk = ~clk;

  datamem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  datamem_ctrl #(.WAIT_CYCLES(0)) dut0w (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_size(req_size1), .req_signed(req_signed1), .req_addr(req_addr1),
    .req_wdata(req_wdata1), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .rsp_err(rsp_err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed memory, executed at accept time.
  task automatic model(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int n, base;
    logic [31:0] v;
    rd = 0;
    er = (sz == 2'b11) || (a < BASE) || ((a - BASE) >= DEPTH*4);
    if (er) return;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = int'(a - BASE) & ~(n - 1);
    if (wr) begin
      for (int i = 0; i < n; i++) mb[base+i] = 8'((wd >> (8*i)) & 32'hFF);
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[base+i]) << (8*i));
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
      rd = v;
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance; scrambles inputs while busy.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd_o, output logic er_o);
    int lat;
    logic [31:0] exp_rd;
    logic exp_er;
    @(negedge clk);
    chk("strobe_1cyc", 32'(rsp_valid), 0);
    chk("idle_ready", 32'(req_ready), 1);
    req_valid = 1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    model(wr, sz, sg, a, wd, exp_rd, exp_er);
    @(posedge clk);
    lat = 0; rd_o = 0; er_o = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        rd_o = rsp_rdata; er_o = rsp_err;
        req_valid = 0;
        break;
      end
      req_valid = 1; req_write = $urandom; req_size = 2'($urandom);
      req_signed = $urandom; req_addr = $urandom; req_wdata = $urandom;
    end
    req_valid = 0;
    chk("latency", 32'(lat), 3);
    chk("rdata", rd_o, exp_rd);
    chk("err", 32'(er_o), 32'(exp_er));
  endtask

  initial begin
    logic [31:0] rd, prev;
    logic er;
    logic wr, sg, seen;
    logic [1:0] sz;
    logic [31:0] a;

    foreach (mb[i]) mb[i] = 8'h00;
    rst_n = 0;
    req_valid = 0; req_write = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    req_valid1 = 0; req_write1 = 0; req_size1 = 0; req_signed1 = 0; req_addr1 = 0; req_wdata1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", 32'(rsp_err), 0);
    rst_n = 1;

    // Store/load round trip
    do_req(1, 2'b10, 0, 32'hFFFFFF10, 32'hDEADBEEF, rd, er);
    do_req(0, 2'b10, 0, 32'hFFFFFF10, 32'h0, rd, er);
    chk("lw_deadbeef", rd, 32'hDEADBEEF);

    // Byte store and signed/unsigned byte loads
    do_req(1, 2'b00, 0, 32'hFFFFFF13, 32'h00000080, rd, er);
    do_req(0, 2'b00, 1, 32'hFFFFFF13, 32'h0, rd, er);
    chk("lb", rd, 32'hFFFFFF80);
    do_req(0, 2'b00, 0, 32'hFFFFFF13, 32'h0, rd, er);
    chk("lbu", rd, 32'h00000080);
    do_req(0, 2'b10, 0, 32'hFFFFFF10, 32'h0, rd, er);
    chk("lw_merge", rd, 32'h80ADBEEF);

    // Rejected requests
    do_req(0, 2'b10, 0, 32'hFFFFFEFC, 32'h0, rd, er);
    chk("below_base_err", 32'(er), 1);
    do_req(0, 2'b10, 0, 32'h00000000, 32'h0, rd, er);
    chk("zero_addr_err", 32'(er), 1);
    do_req(1, 2'b11, 0, 32'hFFFFFF00, 32'hFFFFFFFF, rd, er);
    chk("size11_err", 32'(er), 1);
    do_req(0, 2'b10, 0, 32'hFFFFFF00, 32'h0, rd, er);
    chk("word0_untouched", rd, 32'h0);

    // Misaligned half store
    do_req(1, 2'b01, 0, 32'hFFFFFF21, 32'h00001234, rd, er);
`ifdef DATAMEM_ALIGN_CHECK_EN
    chk("sh_misalign_err", 32'(er), 1);
    do_req(0, 2'b10, 0, 32'hFFFFFF20, 32'h0, rd, er);
    chk("sh_misalign_lw", rd, 32'h0);
`else
    chk("sh_misalign_err", 32'(er), 0);
    do_req(0, 2'b10, 0, 32'hFFFFFF20, 32'h0, rd, er);
    chk("sh_misalign_lw", rd, 32'h00001234);
`endif

    // Reset during WAIT abandons the store
    @(negedge clk);
    req_valid = 1; req_write = 1; req_size = 2'b10; req_signed = 0;
    req_addr = 32'hFFFFFF30; req_wdata = 32'h55AA55AA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    chk("in_wait_ready", 32'(req_ready), 0);
    rst_n = 0;
    #1;
    chk("rst_wait_ready", 32'(req_ready), 1);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    rst_n = 1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("no_rsp_after_rst", 32'(seen), 0);
    do_req(0, 2'b10, 0, 32'hFFFFFF30, 32'h0, rd, er);
    chk("abandoned_store", rd, 32'h0);
    do_req(0, 2'b10, 0, 32'hFFFFFF10, 32'h0, rd, er);
    chk("mem_kept_over_rst", rd, 32'h80ADBEEF);

    // Random traffic against the model
    for (int k = 0; k < 200; k++) begin
      wr = $urandom;
      sg = $urandom;
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 7))
        0:       a = $urandom;
        1:       a = BASE - 32'(4 * $urandom_range(1, 4));
        default: a = BASE + 32'($urandom_range(0, DEPTH*4 + 7));
      endcase
`ifdef DATAMEM_ALIGN_CHECK_EN
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz == 2'b10) a[1:0] = 2'b00;
`endif
      do_req(wr, sz, sg, a, $urandom, rd, er);
    end

    // Zero-wait instance: valid held high, alternating sw/lw
    @(negedge clk);
    req_valid1 = 1; req_size1 = 2'b10; req_signed1 = 0; req_addr1 = 32'hFFFFFF04;
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      chk("w0_ready", 32'(req_ready1), 1);
      req_write1 = (k % 2 == 0);
      if (req_write1) begin
        req_wdata1 = $urandom;
        prev = req_wdata1;
      end
      @(negedge clk);
      chk("w0_rsp_valid", 32'(rsp_valid1), 1);
      chk("w0_busy", 32'(req_ready1), 0);
      chk("w0_err", 32'(rsp_err1), 0);
      chk("w0_rdata", rsp_rdata1, req_write1 ? 32'h0 : prev);
      @(negedge clk);
    end
    req_valid1 = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
